// File: rtl/game_pkg.sv
// Shared types and widths for the high/low guessing game round controller.
package game_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_SCORE,
        S_DONE
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/round_timer.sv
// WAIT-phase watchdog: counts enabled cycles, flags the last allowed one.
module round_timer #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer: arms a guess, waits for an outcome or timeout, scores it,
// and tracks hits/rounds until the game is over.
module round_ctrl
    import game_pkg::*;
#(
    parameter int ROUNDS  = 5,
    parameter int WIN_MIN = 3,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             guess,
    input  logic             fsm_h,
    input  logic             fsm_l,
    output logic             busy,
    output logic             result_valid,
    output logic             hit,
    output logic [CNT_W-1:0] score,
    output logic [CNT_W-1:0] round_num,
    output logic             done,
    output logic             win
);

    localparam logic [CNT_W-1:0] ROUNDS_C = CNT_W'(ROUNDS);
    localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(WIN_MIN);

    state_e           state_q, state_d;
    logic             guess_q, guess_d;
    logic             outc_q, outc_d;
    logic             tmo_q, tmo_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] score_q, score_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic             expired;

    round_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == S_ARM),
        .en      (state_q == S_WAIT),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        guess_d = guess_q;
        outc_d  = outc_q;
        tmo_d   = tmo_q;
        hit_d   = hit_q;
        score_d = score_q;
        round_d = round_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ARM;
                    score_d = '0;
                    round_d = '0;
                    hit_d   = 1'b0;
                end
            end
            S_ARM: begin
                guess_d = guess;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fsm_h) begin
                    outc_d  = 1'b1;
                    tmo_d   = 1'b0;
                    state_d = S_SCORE;
                end else if (fsm_l) begin
                    outc_d  = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_SCORE;
                end else if (expired) begin
                    tmo_d   = 1'b1;
                    state_d = S_SCORE;
                end
            end
            S_SCORE: begin
                state_d = (round_q == ROUNDS_C) ? S_DONE : S_ARM;
            end
            default: state_d = S_IDLE;
        endcase
        // Results are settled on entry so they are valid during SCORE
        if (state_q == S_WAIT && state_d == S_SCORE) begin
            hit_d   = !tmo_d && (outc_d == guess_q);
            score_d = hit_d ? sat_inc(score_q) : score_q;
            round_d = round_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            guess_q <= 1'b0;
            outc_q  <= 1'b0;
            tmo_q   <= 1'b0;
            hit_q   <= 1'b0;
            score_q <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            guess_q <= guess_d;
            outc_q  <= outc_d;
            tmo_q   <= tmo_d;
            hit_q   <= hit_d;
            score_q <= score_d;
            round_q <= round_d;
        end
    end

    assign busy         = (state_q == S_ARM) || (state_q == S_WAIT)
                       || (state_q == S_SCORE);
    assign result_valid = (state_q == S_SCORE);
    assign done         = (state_q == S_DONE);
    assign win          = done && (score_q >= WIN_C);
    assign hit          = hit_q;
    assign score        = score_q;
    assign round_num    = round_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed + randomized bench for round_ctrl against a per-round game model.
module tb_round_ctrl;

    localparam int R  = 5;
    localparam int WM = 3;
    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       rst, start, guess, fsm_h, fsm_l;
    logic       busy, result_valid, hit, done, win;
    logic [3:0] score, round_num;

    int checks = 0;
    int errors = 0;
    int m_score, m_round;

    round_ctrl #(.ROUNDS(R), .WIN_MIN(WM), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .guess        (guess),
        .fsm_h        (fsm_h),
        .fsm_l        (fsm_l),
        .busy         (busy),
        .result_valid (result_valid),
        .hit          (hit),
        .score        (score),
        .round_num    (round_num),
        .done         (done),
        .win          (win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rv"}, int'(result_valid), 0);
        chk({tag, "_hit"}, int'(hit), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_round"}, int'(round_num), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_win"}, int'(win), 0);
    endtask

    // Called at a negedge in IDLE/DONE; returns at the negedge inside ARM.
    task automatic start_game(input bit g);
        start = 1'b1;
        guess = g;
        @(negedge clk);
        start   = 1'b0;
        m_score = 0;
        m_round = 0;
        chk("arm_busy", int'(busy), 1);
        chk("arm_rv", int'(result_valid), 0);
        chk("arm_score", int'(score), 0);
        chk("arm_round", int'(round_num), 0);
        chk("arm_hit", int'(hit), 0);
        chk("arm_done", int'(done), 0);
    endtask

    // kind: 0 none, 1 high, 2 low, 3 both. n = WAIT cycle carrying the pulse.
    // Called at the negedge inside ARM; returns at the negedge after SCORE.
    task automatic play_round(input bit g, input int kind, input int n,
                              input bit armp, input bit sw);
        int w;
        int eh;
        guess = g;
        fsm_h = armp;
        fsm_l = 1'b0;
        w = (kind != 0) ? n : TO;
        for (int i = 1; i <= w; i++) begin
            @(negedge clk);
            fsm_h = 1'b0;
            fsm_l = 1'b0;
            start = 1'b0;
            guess = 1'($urandom);
            chk("wait_rv", int'(result_valid), 0);
            chk("wait_busy", int'(busy), 1);
            if (sw && i == 1) start = 1'b1;
            if (i == w && kind != 0) begin
                fsm_h = (kind == 1 || kind == 3);
                fsm_l = (kind == 2 || kind == 3);
            end
        end
        @(negedge clk);
        fsm_h = 1'b0;
        fsm_l = 1'b0;
        start = 1'b0;
        if (kind == 1 || kind == 3) eh = int'(g);
        else if (kind == 2) eh = int'(!g);
        else eh = 0;
        m_score = (m_score + eh > 15) ? 15 : m_score + eh;
        m_round++;
        chk("score_rv", int'(result_valid), 1);
        chk("score_hit", int'(hit), eh);
        chk("score_score", int'(score), m_score);
        chk("score_round", int'(round_num), m_round);
        @(negedge clk);
        chk("post_rv", int'(result_valid), 0);
        if (m_round == R) begin
            chk("end_done", int'(done), 1);
            chk("end_busy", int'(busy), 0);
            chk("end_win", int'(win), (m_score >= WM) ? 1 : 0);
            chk("end_score", int'(score), m_score);
            chk("end_hit", int'(hit), eh);
        end else begin
            chk("next_busy", int'(busy), 1);
            chk("next_done", int'(done), 0);
        end
    endtask

    task automatic random_game();
        start_game(1'($urandom));
        for (int r = 0; r < R; r++) begin
            play_round(1'($urandom), int'($urandom_range(0, 3)),
                       int'($urandom_range(1, TO)), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        guess = 1'b0;
        fsm_h = 1'b0;
        fsm_l = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("idle");

        // All hits with a high outcome three cycles in
        start_game(1'b1);
        for (int r = 0; r < R; r++) play_round(1'b1, 1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_done", int'(done), 1);
            chk("hold_score", int'(score), R);
            chk("hold_round", int'(round_num), R);
            chk("hold_rv", int'(result_valid), 0);
        end

        // Three low outcomes then two high, guessing high
        start_game(1'b1);
        for (int r = 0; r < R; r++) play_round(1'b1, (r < 3) ? 2 : 1, 3, 1'b0, 1'b0);

        // Every round times out
        start_game(1'b0);
        for (int r = 0; r < R; r++) play_round(1'($urandom), 0, 0, 1'b0, 1'b0);

        // Simultaneous pulses, and a pulse only during ARM
        start_game(1'b1);
        for (int r = 0; r < R; r++) begin
            if (r % 2 == 0) play_round(1'b1, 3, 2, 1'b0, 1'b0);
            else play_round(1'b1, 0, 0, 1'b1, 1'b0);
        end

        // Reset during WAIT of round 3
        start_game(1'b0);
        play_round(1'b0, 2, 4, 1'b0, 1'b0);
        play_round(1'b1, 1, 1, 1'b0, 1'b0);
        guess = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rv", int'(result_valid), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_busy", int'(busy), 0);
            chk("postrst_done", int'(done), 0);
        end
        random_game();

        // Start during WAIT is ignored; start in DONE re-arms
        start_game(1'b1);
        for (int r = 0; r < R; r++) play_round(1'b1, 1, 5, 1'b0, 1'b1);
        for (int g = 0; g < 4; g++) random_game();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
